// File: rtl/dvd_pkg.sv
// Shared constants for the bouncing-sprite renderer.
//   RGB_W       : pixel colour width, {R[1:0],G[1:0],B[1:0]}
//   DVD_PALETTE : 8-entry colour table indexed by a sprite's colour index
package dvd_pkg;

    localparam int unsigned RGB_W = 6;

    // Entry 0 is the rightmost element of the concatenation.
    localparam logic [7:0][RGB_W-1:0] DVD_PALETTE = {
        6'b10_10_10,
        6'b11_11_11,
        6'b11_00_11,
        6'b00_11_11,
        6'b11_11_00,
        6'b00_00_11,
        6'b00_11_00,
        6'b11_00_00
    };

endpackage

// File: rtl/bounce_axis.sv
// One axis of a bouncing sprite: a 0..MAX coordinate with a direction bit.
//   clk, reset          : pixel clock, async active-high reset
//   step                : advance one motion step this cycle
//   load                : reload coordinate/direction (wins over step)
//   load_val, load_dir  : values applied on load
//   pos, dir            : current coordinate and direction (1 = increasing)
//   bounce              : combinational; this step hits a wall
module bounce_axis #(
    parameter int unsigned MAX     = 19,
    parameter int unsigned W       = 5,
    parameter int unsigned RST_POS = 0,
    parameter bit          RST_DIR = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         step,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         load_dir,
    output logic [W-1:0] pos,
    output logic         dir,
    output logic         bounce
);

    logic at_wall_c;

    assign at_wall_c = dir ? (pos == W'(MAX)) : (pos == '0);
    assign bounce    = step & at_wall_c & ~load;

    // A bounce flips direction and holds the coordinate for that step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos <= W'(RST_POS);
            dir <= RST_DIR;
        end else if (load) begin
            pos <= load_val;
            dir <= load_dir;
        end else if (step) begin
            if (at_wall_c) begin
                dir <= ~dir;
            end else begin
                pos <= dir ? pos + W'(1) : pos - W'(1);
            end
        end
    end

endmodule

// File: rtl/bounce_sprite_engine.sv
// Multi-sprite bouncing-cell renderer on the pixel clock.
//   clk, reset                  : pixel clock, async active-high reset
//   enable, restart, dir_seed   : motion control and restart direction seed
//   bg_color                    : background colour
//   hsync_in, vsync_in, video_active, pix_x, pix_y : from the sync generator
//   rgb, hsync_out, vsync_out   : registered pixel and one-cycle delayed syncs
//   corner_pulse, corner_count  : corner-hit pulse and saturating hit count
module bounce_sprite_engine
    import dvd_pkg::*;
#(
    parameter int unsigned NUM_SPRITES = 2,
    parameter int unsigned CELL_LOG2   = 5,
    parameter int unsigned GRID_W      = 20,
    parameter int unsigned GRID_H      = 15,
    parameter int unsigned FRAME_DIV   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     restart,
    input  logic [2*NUM_SPRITES-1:0] dir_seed,
    input  logic [RGB_W-1:0]         bg_color,
    input  logic                     hsync_in,
    input  logic                     vsync_in,
    input  logic                     video_active,
    input  logic [9:0]               pix_x,
    input  logic [9:0]               pix_y,
    output logic [RGB_W-1:0]         rgb,
    output logic                     hsync_out,
    output logic                     vsync_out,
    output logic                     corner_pulse,
    output logic [7:0]               corner_count
);

    localparam int unsigned XW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
    localparam int unsigned YW = (GRID_H > 1) ? $clog2(GRID_H) : 1;
    localparam int unsigned DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int unsigned CW = 10 - CELL_LOG2;

    // Frame divider driven by a synchronous vsync rising-edge detector.
    logic          vsync_q;
    logic [DW-1:0] div_cnt;
    logic          frame_edge_c;
    logic          div_last_c;
    logic          step_c;

    assign frame_edge_c = vsync_in & ~vsync_q;
    assign div_last_c   = (div_cnt == DW'(FRAME_DIV - 1));
    assign step_c       = enable & frame_edge_c & div_last_c & ~restart;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_q <= 1'b0;
            div_cnt <= '0;
        end else begin
            vsync_q <= vsync_in;
            if (restart) begin
                div_cnt <= '0;
            end else if (enable && frame_edge_c) begin
                div_cnt <= div_last_c ? '0 : div_cnt + DW'(1);
            end
        end
    end

    // Per-sprite axis state.
    logic [XW-1:0]          pos_x [NUM_SPRITES];
    logic [YW-1:0]          pos_y [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] dir_x;
    logic [NUM_SPRITES-1:0] dir_y;
    logic [NUM_SPRITES-1:0] bounce_x;
    logic [NUM_SPRITES-1:0] bounce_y;

    for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_sprite
        localparam int unsigned X0 = (GRID_W / 2 + 3 * i) % GRID_W;
        localparam int unsigned Y0 = (GRID_H / 2 + 2 * i) % GRID_H;

        bounce_axis #(
            .MAX(GRID_W - 1), .W(XW), .RST_POS(X0), .RST_DIR(1'((i % 2) == 0))
        ) u_x (
            .clk(clk), .reset(reset), .step(step_c), .load(restart),
            .load_val(XW'(X0)), .load_dir(dir_seed[2*i]),
            .pos(pos_x[i]), .dir(dir_x[i]), .bounce(bounce_x[i])
        );

        bounce_axis #(
            .MAX(GRID_H - 1), .W(YW), .RST_POS(Y0), .RST_DIR(1'b1)
        ) u_y (
            .clk(clk), .reset(reset), .step(step_c), .load(restart),
            .load_val(YW'(Y0)), .load_dir(dir_seed[2*i+1]),
            .pos(pos_y[i]), .dir(dir_y[i]), .bounce(bounce_y[i])
        );
    end

    // Directions and sub-cell pixel bits are not needed at this level.
    logic unused_bits_c;
    assign unused_bits_c = &{1'b0, dir_x, dir_y, pix_x[CELL_LOG2-1:0], pix_y[CELL_LOG2-1:0]};

    // Colour index advances on any bounce of its sprite.
    logic [2:0] color [NUM_SPRITES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) color[i] <= 3'(i);
        end else if (restart) begin
            for (int i = 0; i < NUM_SPRITES; i++) color[i] <= 3'(i);
        end else begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (bounce_x[i] || bounce_y[i]) color[i] <= color[i] + 3'd1;
            end
        end
    end

    // Corner hits: both axes of one sprite bounce in the same step.
    logic [NUM_SPRITES-1:0] corner_c;
    logic [2:0]             n_corner_c;
    logic [8:0]             count_sum_c;

    assign corner_c = bounce_x & bounce_y;

    always_comb begin
        n_corner_c = '0;
        for (int i = 0; i < NUM_SPRITES; i++) n_corner_c = n_corner_c + 3'(corner_c[i]);
    end

    assign count_sum_c = {1'b0, corner_count} + 9'(n_corner_c);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            corner_pulse <= 1'b0;
            corner_count <= '0;
        end else begin
            corner_pulse <= |corner_c;
            if (|corner_c) corner_count <= count_sum_c[8] ? 8'hFF : count_sum_c[7:0];
        end
    end

    // Cell match; scanning downward leaves the lowest-index hit selected.
    logic       hit_c;
    logic [2:0] hit_color_c;

    always_comb begin
        hit_c       = 1'b0;
        hit_color_c = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (pix_x[9:CELL_LOG2] == CW'(pos_x[i]) && pix_y[9:CELL_LOG2] == CW'(pos_y[i])) begin
                hit_c       = 1'b1;
                hit_color_c = color[i];
            end
        end
    end

    // Output registers: one cycle of latency for pixel and syncs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb       <= '0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
        end else begin
            hsync_out <= hsync_in;
            vsync_out <= vsync_in;
            if (!video_active) rgb <= '0;
            else if (hit_c)    rgb <= DVD_PALETTE[hit_color_c];
            else               rgb <= bg_color;
        end
    end

endmodule

// File: tb/tb_bounce_sprite_engine.sv
// Directed bench for bounce_sprite_engine.
// Instance a: default parameters (20x15 grid, two sprites, FRAME_DIV=2).
// Instance b: 3x2 grid, two sprites starting on the same cell, FRAME_DIV=1,
// which makes overlap, corner hits and count saturation quick to reach.
module tb_bounce_sprite_engine;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       restart;
    logic [3:0] dir_seed_a;
    logic [3:0] dir_seed_b;
    logic       restart_b;
    logic [5:0] bg_color;
    logic       hsync_in;
    logic       vsync_a;
    logic       vsync_b;
    logic       video_active;
    logic [9:0] pix_x;
    logic [9:0] pix_y;

    logic [5:0] rgb_a,    rgb_b;
    logic       hs_out_a, hs_out_b;
    logic       vs_out_a, vs_out_b;
    logic       pulse_a,  pulse_b;
    logic [7:0] count_a,  count_b;

    int n_cmp = 0;
    int n_bad = 0;

    bounce_sprite_engine u_a (
        .clk(clk), .reset(reset), .enable(enable), .restart(restart),
        .dir_seed(dir_seed_a), .bg_color(bg_color), .hsync_in(hsync_in),
        .vsync_in(vsync_a), .video_active(video_active), .pix_x(pix_x), .pix_y(pix_y),
        .rgb(rgb_a), .hsync_out(hs_out_a), .vsync_out(vs_out_a),
        .corner_pulse(pulse_a), .corner_count(count_a)
    );

    bounce_sprite_engine #(
        .NUM_SPRITES(2), .CELL_LOG2(5), .GRID_W(3), .GRID_H(2), .FRAME_DIV(1)
    ) u_b (
        .clk(clk), .reset(reset), .enable(enable), .restart(restart_b),
        .dir_seed(dir_seed_b), .bg_color(bg_color), .hsync_in(hsync_in),
        .vsync_in(vsync_b), .video_active(video_active), .pix_x(pix_x), .pix_y(pix_y),
        .rgb(rgb_b), .hsync_out(hs_out_b), .vsync_out(vs_out_b),
        .corner_pulse(pulse_b), .corner_count(count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic look(input int x, input int y);
        pix_x = 10'(x);
        pix_y = 10'(y);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_va();
        vsync_a = 1'b1;
        @(posedge clk);
        #1;
        vsync_a = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_vb();
        vsync_b = 1'b1;
        @(posedge clk);
        #1;
        vsync_b = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        enable       = 1'b1;
        restart      = 1'b0;
        restart_b    = 1'b0;
        dir_seed_a   = 4'b0000;
        dir_seed_b   = 4'b0000;
        bg_color     = 6'b000001;
        hsync_in     = 1'b0;
        vsync_a      = 1'b0;
        vsync_b      = 1'b0;
        video_active = 1'b0;
        pix_x        = '0;
        pix_y        = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rgb", 32'(rgb_a), 32'h0);
        chk("rst_hsync", 32'(hs_out_a), 32'h0);
        chk("rst_vsync", 32'(vs_out_a), 32'h0);
        chk("rst_pulse", 32'(pulse_a), 32'h0);
        chk("rst_count", 32'(count_a), 32'h0);
        reset = 1'b0;

        // Initial render: sprite 0 at (10,7), sprite 1 at (13,9)
        video_active = 1'b1;
        look(320, 224);
        chk("init_s0", 32'(rgb_a), 32'b110000);
        look(416, 288);
        chk("init_s1", 32'(rgb_a), 32'b001100);
        look(0, 0);
        chk("init_bg", 32'(rgb_a), 32'b000001);
        look(32, 32);
        chk("b_overlap_init", 32'(rgb_b), 32'b110000);

        // Two vsync edges make one step; first edge alone changes nothing
        vsync_a = 1'b1;
        @(posedge clk);
        #1;
        chk("vsync_delay_hi", 32'(vs_out_a), 32'h1);
        vsync_a = 1'b0;
        @(posedge clk);
        #1;
        chk("vsync_delay_lo", 32'(vs_out_a), 32'h0);
        look(320, 224);
        chk("div_hold_s0", 32'(rgb_a), 32'b110000);
        pulse_va();
        look(352, 256);
        chk("step1_s0_new", 32'(rgb_a), 32'b110000);
        look(320, 224);
        chk("step1_s0_old", 32'(rgb_a), 32'b000001);
        look(384, 320);
        chk("step1_s1_new", 32'(rgb_a), 32'b001100);

        // Sync delay and blanking
        hsync_in = 1'b1;
        @(posedge clk);
        #1;
        chk("hsync_delay_hi", 32'(hs_out_a), 32'h1);
        hsync_in = 1'b0;
        @(posedge clk);
        #1;
        chk("hsync_delay_lo", 32'(hs_out_a), 32'h0);
        video_active = 1'b0;
        look(352, 256);
        chk("blank_rgb", 32'(rgb_a), 32'h0);
        video_active = 1'b1;

        // enable=0 freezes divider and positions across 10 edges
        pulse_va();
        enable = 1'b0;
        for (int k = 0; k < 10; k++) pulse_va();
        enable = 1'b1;
        look(352, 256);
        chk("frozen_s0", 32'(rgb_a), 32'b110000);
        pulse_va();
        look(384, 288);
        chk("resume_step_s0", 32'(rgb_a), 32'b110000);
        look(352, 256);
        chk("resume_old_s0", 32'(rgb_a), 32'b000001);

        // Restart: sprite 0 x+/y+, sprite 1 x-/y-
        dir_seed_a = 4'b0011;
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        look(320, 224);
        chk("restart_s0", 32'(rgb_a), 32'b110000);
        look(384, 288);
        chk("restart_old", 32'(rgb_a), 32'b000001);

        // 9 steps: x reaches 19, y bounced at 14 on step 8 (colour 1), now 13
        for (int k = 0; k < 18; k++) pulse_va();
        look(608, 416);
        chk("s0_edge_x19", 32'(rgb_a), 32'b001100);
        // Step 10: x bounces and holds 19, colour 2, y 12
        repeat (2) pulse_va();
        look(608, 384);
        chk("s0_bounce_hold", 32'(rgb_a), 32'b000011);
        // Step 11: x leaves the edge to 18, y 11
        repeat (2) pulse_va();
        look(576, 352);
        chk("s0_after_bounce", 32'(rgb_a), 32'b000011);
        look(608, 384);
        chk("s0_edge_vacated", 32'(rgb_a), 32'b000001);
        chk("a_no_corner", 32'(count_a), 32'h0);

        // Instance b: step 1 -> s0 (2,1) c1, s1 (0,1) c2
        pulse_vb();
        look(64, 32);
        chk("b_s1_s0", 32'(rgb_b), 32'b001100);
        look(0, 32);
        chk("b_s1_s1", 32'(rgb_b), 32'b000011);
        // Steps 2,3 -> both at (1,0), s0 colour 3 shown
        repeat (2) pulse_vb();
        look(32, 0);
        chk("b_overlap_s3", 32'(rgb_b), 32'b111100);
        // Step 4 -> s0 (0,1), s1 (2,1); step 5 both sprites hit a corner
        pulse_vb();
        chk("b_no_pulse", 32'(pulse_b), 32'h0);
        vsync_b = 1'b1;
        @(posedge clk);
        #1;
        chk("b_corner_pulse", 32'(pulse_b), 32'h1);
        chk("b_corner_count2", 32'(count_b), 32'd2);
        vsync_b = 1'b0;
        @(posedge clk);
        #1;
        chk("b_pulse_one_cycle", 32'(pulse_b), 32'h0);
        look(0, 32);
        chk("b_corner_hold_s0", 32'(rgb_b), 32'b001111);
        look(64, 32);
        chk("b_corner_hold_s1", 32'(rgb_b), 32'b110011);
        // Next corner pair at step 11
        for (int k = 0; k < 6; k++) pulse_vb();
        chk("b_corner_count4", 32'(count_b), 32'd4);
        // Many more corners: count saturates at 255
        for (int k = 0; k < 800; k++) pulse_vb();
        chk("b_count_sat", 32'(count_b), 32'd255);

        // Reset asserted mid-frame clears everything at once
        hsync_in = 1'b1;
        look(576, 352);
        chk("pre_reset_rgb", 32'(rgb_a), 32'b000011);
        chk("pre_reset_hs", 32'(hs_out_a), 32'h1);
        reset = 1'b1;
        #1;
        chk("mid_rst_rgb", 32'(rgb_a), 32'h0);
        chk("mid_rst_hs", 32'(hs_out_a), 32'h0);
        chk("mid_rst_vs", 32'(vs_out_a), 32'h0);
        chk("mid_rst_count_b", 32'(count_b), 32'h0);
        chk("mid_rst_pulse_b", 32'(pulse_b), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        look(320, 224);
        chk("post_rst_s0", 32'(rgb_a), 32'b110000);
        chk("post_rst_hs", 32'(hs_out_a), 32'h1);
        look(32, 32);
        chk("post_rst_b_overlap", 32'(rgb_b), 32'b110000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bounce_sprite_engine.md
# bounce_sprite_engine

Parametrised multi-sprite bouncing-cell renderer for the TinyVGA output path. It sits between `hvsync_generator` and the PMOD pin mapping. The block moves NUM_SPRITES grid-aligned square sprites that bounce off the grid edges, and produces a registered 6-bit RGB pixel stream plus delayed syncs. All logic runs on the pixel clock: frame steps come from a synchronous vsync edge detector with a programmable frame divider, not from vsync-clocked flops. It adds per-sprite colour cycling on every bounce and corner-hit detection.

## Interface
- NUM_SPRITES, 2: number of sprites, 1..4
- CELL_LOG2, 5: sprite/cell size is 2^CELL_LOG2 pixels square
- GRID_W, 20: cells across; GRID_W<<CELL_LOG2 ≤ 1024
- GRID_H, 15: cells down; GRID_H<<CELL_LOG2 ≤ 1024
- FRAME_DIV, 2: vsync rising edges per motion step, ≥1
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  1 = motion runs; 0 = divider and positions frozen, rendering continues
- restart  in  1  synchronous one-cycle reload of positions/directions/colours
- dir_seed  in  2*NUM_SPRITES  on restart: bit 2i = dir_x of sprite i, bit 2i+1 = dir_y (1 = increasing)
- bg_color  in  6  background {R[1:0],G[1:0],B[1:0]}
- hsync_in, vsync_in, video_active  in  1 each  from hvsync_generator
- pix_x, pix_y  in  10 each  from hvsync_generator
- rgb  out  6  registered pixel colour
- hsync_out, vsync_out  out  1 each  syncs delayed one cycle to align with rgb
- corner_pulse  out  1  one-cycle pulse on any corner hit
- corner_count  out  8  saturating count of corner hits

## Operation
- Per sprite i: x_i (clog2(GRID_W) bits), y_i (clog2(GRID_H) bits), dir_x_i, dir_y_i, colour index c_i (3 bits) into the 8-entry palette.
- Reset/restart values: x_i = (GRID_W/2 + 3i) mod GRID_W, y_i = (GRID_H/2 + 2i) mod GRID_H, c_i = i. On reset: dir_x_i = ~i[0], dir_y_i = 1. On restart: directions come from dir_seed. div_cnt = 0. Restart does not clear corner_count; reset does.
- Frame edge: vsync_q <= vsync_in; edge = vsync_in & ~vsync_q. When enable=1 and edge=1:
  - if div_cnt == FRAME_DIV-1, a step occurs and div_cnt <= 0;
  - otherwise div_cnt increments.
- Step, per axis, independently per sprite:
  - moving up and coordinate == max (GRID_W-1 or GRID_H-1): flip direction, hold coordinate (bounce);
  - moving down and coordinate == 0: flip direction, hold coordinate (bounce);
  - otherwise ±1.
- Any bounce on a sprite during a step increments c_i, mod 8.
- A step where both axes of one sprite bounce is a corner hit. corner_pulse is 1 for that cycle, and corner_count increments by the number of corner-hitting sprites, saturating at 255.
- Priority: restart > step.
- Render: cell match for sprite i when pix_x[9:CELL_LOG2] == x_i and pix_y[9:CELL_LOG2] == y_i, with the x/y registers zero-extended.
  - If video_active=0: rgb <= 0.
  - Else if any sprite matches: rgb <= palette[c_k], where k is the lowest-index matching sprite.
  - Else: rgb <= bg_color.

## Timing
- Reset state of outputs: rgb=0, hsync_out=0, vsync_out=0, corner_pulse=0, corner_count=0.
- Render latency: exactly 1 clk from pix_x/pix_y/video_active/syncs to rgb/hsync_out/vsync_out.
- A step updates state at the clock edge that samples the qualifying vsync edge. New positions are visible in rgb from the next cycle.
- Because of the one-step dwell at a bounce, a sprite shows the edge cell for two steps.
- If enable falls with div_cnt nonzero, the value is held. It resumes counting when enable returns.
- Reset asserted mid-frame clears all state immediately. Rendering restarts on the first cycle after release.

## Structure
- Shared package `dvd_pkg`:
  - 8-entry palette constant `DVD_PALETTE`: 6'b11_00_00, 00_11_00, 00_00_11, 11_11_00, 00_11_11, 11_00_11, 11_11_11, 10_10_10;
  - `RGB_W = 6`.
- One sub-module, `bounce_axis`, instantiated twice per sprite. Parameter MAX. Ports: clk, reset, step, load, load_val, load_dir. Outputs: pos, dir, bounce.
- The top level holds the divider, corner logic, priority mux and output registers.

## Test plan
- Reset, default params → sprite 0 at (10,7), sprite 1 at (13,9); rgb=0; corner_count=0. Pixel (320,224) active gives rgb=palette[0]=6'b110000.
- FRAME_DIV=2, enable=1, two vsync rising edges → one step: sprite 0 (dir_x=1, dir_y=1) moves to (11,8); no change after the first edge alone.
- Restart with sprite 0 forced to x=19, dir_x=1 and steps → first step: x stays 19, dir_x=0, c_0=1. Next step: x=18.
- Sprite 0 at (19,14), both dirs increasing, one step → corner_pulse for one cycle, corner_count=1, c_0=1, position unchanged.
- Both sprites on the same cell → rgb = sprite 0 colour. video_active=0 → rgb=0. hsync_out equals hsync_in delayed by 1 cycle.
- enable=0 across 10 vsync edges → positions and div_cnt unchanged. Assert reset mid-frame → all outputs return to reset values.
